// File: rtl/seq_detector_compare.sv
// Mealy/Moore detector pair for one PATTERN, advanced on rising edges of step,
// with saturating per-machine detection counters and a sticky disagreement flag.
module seq_detector_compare #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     CNT_W       = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             step,
  input  logic                             din,
  input  logic                             clear_cnt,
  output logic                             z_mealy,
  output logic [$clog2(PATTERN_LEN)-1:0]   state_mealy,
  output logic                             z_moore,
  output logic [$clog2(PATTERN_LEN+1)-1:0] state_moore,
  output logic [CNT_W-1:0]                 cnt_mealy,
  output logic [CNT_W-1:0]                 cnt_moore,
  output logic                             mismatch
);

  localparam int L  = PATTERN_LEN;
  localparam int MW = $clog2(L);
  localparam int OW = $clog2(L + 1);

  // Longest pattern prefix that is a suffix of (prefix of length k, then bit b).
  function automatic int kmp_next(input int k, input int b);
    int  n, best, idx;
    bit  ok, s;
    n    = k + 1;
    best = 0;
    for (int j = 1; j <= L; j++) begin
      if (j <= n) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          idx = n - j + i;
          s   = (idx < k) ? PATTERN[L-1-idx] : b[0];
          if (s != PATTERN[L-1-i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  function automatic int fail_len();
    int best;
    bit ok;
    best = 0;
    for (int j = 1; j < L; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (PATTERN[j-1-i] != PATTERN[L-1-i]) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  localparam int FAIL = fail_len();

  logic [OW-1:0] moore_tab [L+1][2];
  logic [MW-1:0] mealy_tab [L][2];

  for (genvar gi = 0; gi <= L; gi++) begin : g_moore
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      localparam int SRC = (gi == L && !OVERLAP) ? 0 : gi;
      localparam int NXT = kmp_next(SRC, gb);
      assign moore_tab[gi][gb] = OW'(NXT);
    end
  end

  for (genvar gi = 0; gi < L; gi++) begin : g_mealy
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      localparam bit DONE = (gi == L - 1) && (gb == int'(PATTERN[0]));
      localparam int NXT  = DONE ? (OVERLAP ? FAIL : 0) : kmp_next(gi, gb);
      assign mealy_tab[gi][gb] = MW'(NXT);
    end
  end

  logic             step_q;
  logic             adv;
  logic [MW-1:0]    mealy_q, mealy_d;
  logic [OW-1:0]    moore_q, moore_d;
  logic [CNT_W-1:0] cnt_mealy_q, cnt_mealy_d;
  logic [CNT_W-1:0] cnt_moore_q, cnt_moore_d;
  logic             hit_q, hit_d;
  logic             chk_q, chk_d;
  logic             mismatch_q, mismatch_d;

  assign adv     = step & ~step_q;
  assign z_mealy = (mealy_q == MW'(L - 1)) && (din == PATTERN[0]);
  assign z_moore = (moore_q == OW'(L));

  always_comb begin
    mealy_d     = mealy_q;
    moore_d     = moore_q;
    cnt_mealy_d = cnt_mealy_q;
    cnt_moore_d = cnt_moore_q;
    hit_d       = hit_q;
    chk_d       = 1'b0;
    mismatch_d  = mismatch_q;

    if (adv) begin
      mealy_d = mealy_tab[mealy_q][din];
      moore_d = moore_tab[moore_q][din];
      hit_d   = z_mealy;
      chk_d   = 1'b1;
    end

    // Clear outranks both counting and setting the flag.
    if (clear_cnt) begin
      cnt_mealy_d = '0;
      cnt_moore_d = '0;
      mismatch_d  = 1'b0;
    end else begin
      if (adv && z_mealy && (cnt_mealy_q != '1)) cnt_mealy_d = cnt_mealy_q + 1'b1;
      if (adv && (moore_d == OW'(L)) && (cnt_moore_q != '1)) cnt_moore_d = cnt_moore_q + 1'b1;
      if (chk_q && (z_moore != hit_q)) mismatch_d = 1'b1;
    end
  end

  // step_q resets high so a step held through reset is not seen as a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q      <= 1'b1;
      mealy_q     <= '0;
      moore_q     <= '0;
      cnt_mealy_q <= '0;
      cnt_moore_q <= '0;
      hit_q       <= 1'b0;
      chk_q       <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      step_q      <= step;
      mealy_q     <= mealy_d;
      moore_q     <= moore_d;
      cnt_mealy_q <= cnt_mealy_d;
      cnt_moore_q <= cnt_moore_d;
      hit_q       <= hit_d;
      chk_q       <= chk_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign state_mealy = mealy_q;
  assign state_moore = moore_q;
  assign cnt_mealy   = cnt_mealy_q;
  assign cnt_moore   = cnt_moore_q;
  assign mismatch    = mismatch_q;

endmodule
